sad_block_ctrl: RTL and testbench
=================================

# sad_block_ctrl

Sum-of-absolute-differences scheduler for block matching in the compression pipeline. Per search, it streams `N_CAND` candidate blocks of `N_PIX` pixel pairs through the shared ALU datapath. The datapath forms |cur−ref| with `subtractor8`, accumulates with `adder12` and tracks the minimum with `comparator12`. The block reports the best candidate index and its SAD to the motion-estimation stage.

## Interface
Parameters:
- `N_PIX`, 16: pixel pairs per candidate; must be ≤16 so the worst-case SAD (16×255 = 4080) fits 12 bits.
- `N_CAND`, 8: candidates per search; ≥1.
- `IDX_W`, `$clog2(N_CAND)` (min 1): candidate index width.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle search request; sampled only in IDLE or DONE.
- `in_valid` input 1: pixel pair valid.
- `in_ready` output 1: pair accepted when `in_valid & in_ready` at a rising edge.
- `cur_pix` input 8: current-block pixel.
- `ref_pix` input 8: reference-candidate pixel.
- `busy` output 1: high from the cycle after an accepted `start` through the final best update.
- `done` output 1: one-cycle pulse; the result outputs are valid.
- `best_sad` output 12: minimum SAD; held until the next accepted `start`.
- `best_idx` output `IDX_W`: candidate index of `best_sad`; held likewise.

## Operation
- States:
  - IDLE: `start` → RUN.
  - RUN: last pair of the last candidate accepted → DRAIN.
  - DRAIN: 3 cycles, pipeline empties → DONE.
  - DONE: 1 cycle → IDLE; a `start` sampled here goes directly to RUN.
- On accepted `start`:
  - `pix_cnt` and `cand_cnt` clear to 0.
  - Internal best register loads 12'hFFF and best index loads 0. Any real SAD (≤4080) therefore replaces it.
  - Output `best_sad`/`best_idx` are not updated until `done`.
- `in_ready` = 1 only in RUN. There is no internal backpressure, and gaps in `in_valid` simply stall counting.
- Pipeline, per accepted pair:
  - S1 registers |cur−ref| (8 bits, from `subtractor8`) plus first, last and candidate-index tags.
  - S2: `acc` ← (first ? 0 : acc) + diff, zero-extended to 12 bits via `adder12`. On last, `cand_sad` ← the new sum and `cand_idx` ← the tag.
  - S3: if `comparator12(best, cand_sad)` reports best > `cand_sad` (strictly), best ← `cand_sad` and idx ← `cand_idx`.
- Ties keep the earlier (lower) index.
- Counters:
  - `pix_cnt` wraps from `N_PIX`−1 to 0 and increments `cand_cnt`.
  - `cand_cnt` never wraps within a search.
- `start` in RUN or DRAIN is ignored with no side effect.
- `rst` at any time, including mid-RUN, forces all of the following at the next edge:
  - state IDLE
  - all counters and pipeline valids 0
  - `in_ready`, `busy`, `done` = 0
  - `best_sad` = 0, `best_idx` = 0
- In-flight data is discarded.

## Timing
- Reset values: `in_ready` 0, `busy` 0, `done` 0, `best_sad` 0, `best_idx` 0, plus `cand_valid`/`cand_sad`/`cand_idx` 0 when enabled.
- `start` at edge s: `in_ready` and `busy` are high from the cycle after s.
- Last pair accepted at edge k:
  - S1 at k+1, S2 at k+2, S3 best update at k+3.
  - `best_sad`/`best_idx` registered and `done` = 1 after edge k+4, for one cycle.
  - `busy` drops with `done`.
- `in_ready` drops after edge k.
- Minimum search length is `N_PIX`×`N_CAND` + 5 cycles.

## Configuration
- `SAD_CAND_OUT_EN` defined: adds outputs `cand_valid` (1), `cand_sad` (12) and `cand_idx` (`IDX_W`).
  - `cand_valid` pulses for one cycle, after the S2 edge of each candidate's last pair, carrying that candidate's SAD.
  - N_CAND pulses per search, in index order.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

## Structure
- Package `sad_pkg`:
  - state enum `sad_state_t` (IDLE, RUN, DRAIN, DONE)
  - `PIX_W`=8, `SAD_W`=12, `SAD_INIT`=12'hFFF
- Sub-module `sad_datapath`:
  - instances `subtractor8`, `adder12` and `comparator12`, purely combinational
  - inputs: pixel pair, `acc`, `cand_sad`, best
  - outputs: diff, sum, replace flag
- `sad_block_ctrl` owns the FSM, counters, tags and all registers.

## Test plan
- `N_PIX`=16, `N_CAND`=8, all pixels 0 → `best_sad`=0, `best_idx`=0, `done` exactly 4 cycles after the last accept.
- cur=255, ref=0 for all candidates except candidate 5 (ref=cur) → `best_sad`=0, `best_idx`=5; with `SAD_CAND_OUT_EN`, the `cand_sad` values are 4080 ×5, 0, 4080 ×2.
- Candidates 1 and 3 both SAD 100, others 200 → `best_idx`=1, `best_sad`=100 (tie keeps the lower index).
- Same stimulus with random `in_valid` gaps versus back-to-back → identical results; `in_ready` never high outside RUN.
- `start` re-pulsed during RUN and during DRAIN → ignored; one `done`, correct result.
- `rst` asserted mid-RUN (candidate 3, pixel 7) → all outputs 0 next cycle; a subsequent clean search returns the expected result.

Source files
------------

// File: rtl/sad_block_ctrl_pkg.sv
// Shared types and constants for the SAD block-matching scheduler.
// Imported by sad_datapath and sad_block_ctrl.
package sad_pkg;

  localparam int PIX_W = 8;
  localparam int SAD_W = 12;
  localparam logic [SAD_W-1:0] SAD_INIT = 12'hFFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } sad_state_t;

endpackage

// File: rtl/sad_block_ctrl_datapath.sv
// Combinational ALU slice for SAD: abs difference, accumulate, min compare.
// Leaf cells subtractor8/adder12/comparator12 live here with their user.

// Absolute difference of two 8-bit pixels.
module subtractor8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] d
);
  assign d = (a >= b) ? (a - b) : (b - a);
endmodule

// 12-bit adder; SAD range guarantees no carry out.
module adder12 (
  input  logic [11:0] a,
  input  logic [11:0] b,
  output logic [11:0] s
);
  assign s = a + b;
endmodule

// Strict greater-than for 12-bit SAD values.
module comparator12 (
  input  logic [11:0] a,
  input  logic [11:0] b,
  output logic        gt
);
  assign gt = (a > b);
endmodule

module sad_datapath
  import sad_pkg::*;
(
  input  logic [PIX_W-1:0] cur_pix,
  input  logic [PIX_W-1:0] ref_pix,
  input  logic [SAD_W-1:0] acc,
  input  logic             first,
  input  logic [PIX_W-1:0] acc_diff,
  input  logic [SAD_W-1:0] cand_sad,
  input  logic [SAD_W-1:0] best,
  output logic [PIX_W-1:0] abs_diff,
  output logic [SAD_W-1:0] sum,
  output logic             replace
);

  logic [SAD_W-1:0] acc_base;
  logic [SAD_W-1:0] diff_ext;

  assign acc_base = first ? '0 : acc;
  assign diff_ext = {{(SAD_W-PIX_W){1'b0}}, acc_diff};

  subtractor8 u_sub (
    .a (cur_pix),
    .b (ref_pix),
    .d (abs_diff)
  );

  adder12 u_add (
    .a (acc_base),
    .b (diff_ext),
    .s (sum)
  );

  // Ties are not a replacement, so the lower index wins.
  comparator12 u_cmp (
    .a  (best),
    .b  (cand_sad),
    .gt (replace)
  );

endmodule

// File: rtl/sad_block_ctrl.sv
// SAD scheduler: streams N_CAND x N_PIX pixel pairs, reports best candidate.
// Optional candidate outputs under macro SAD_CAND_OUT_EN.
module sad_block_ctrl
  import sad_pkg::*;
#(
  parameter int N_PIX  = 16,
  parameter int N_CAND = 8,
  parameter int IDX_W  = (N_CAND > 1) ? $clog2(N_CAND) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] cur_pix,
  input  logic [PIX_W-1:0] ref_pix,
  output logic             busy,
  output logic             done,
`ifdef SAD_CAND_OUT_EN
  output logic             cand_valid,
  output logic [SAD_W-1:0] cand_sad,
  output logic [IDX_W-1:0] cand_idx,
`endif
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx
);

  localparam int PC_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;

  sad_state_t state, nstate;

  logic [PC_W-1:0]  pix_cnt;
  logic [IDX_W-1:0] cand_cnt;
  logic [1:0]       drain_cnt;

  logic start_go, fire, last_pix, last_cand;

  logic             p0_v, p0_first, p0_last;
  logic [PIX_W-1:0] p0_cur, p0_ref;
  logic [IDX_W-1:0] p0_idx;

  logic             s1_v, s1_first, s1_last;
  logic [PIX_W-1:0] s1_diff;
  logic [IDX_W-1:0] s1_idx;

  logic [SAD_W-1:0] acc;
  logic             c_v;
  logic [SAD_W-1:0] c_sad;
  logic [IDX_W-1:0] c_idx;

  logic [SAD_W-1:0] best;
  logic [IDX_W-1:0] best_i;

  logic [PIX_W-1:0] abs_diff;
  logic [SAD_W-1:0] sum;
  logic             replace;

  assign in_ready  = (state == RUN);
  assign busy      = (state != IDLE);
  assign fire      = in_valid & in_ready;
  assign start_go  = start & ((state == IDLE) | (state == DONE));
  assign last_pix  = (pix_cnt == PC_W'(N_PIX - 1));
  assign last_cand = (cand_cnt == IDX_W'(N_CAND - 1));

  sad_datapath u_dp (
    .cur_pix  (p0_cur),
    .ref_pix  (p0_ref),
    .acc      (acc),
    .first    (s1_first),
    .acc_diff (s1_diff),
    .cand_sad (c_sad),
    .best     (best),
    .abs_diff (abs_diff),
    .sum      (sum),
    .replace  (replace)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next-state logic.
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (start) nstate = RUN;
      RUN:     if (fire && last_pix && last_cand) nstate = DRAIN;
      DRAIN:   if (drain_cnt == 2'd2) nstate = DONE;
      DONE:    nstate = start ? RUN : IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Pixel/candidate counters and drain timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt   <= '0;
      cand_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      if (start_go) begin
        pix_cnt  <= '0;
        cand_cnt <= '0;
      end else if (fire) begin
        if (last_pix) begin
          pix_cnt <= '0;
          if (!last_cand) cand_cnt <= cand_cnt + 1'b1;
        end else begin
          pix_cnt <= pix_cnt + 1'b1;
        end
      end
    end
  end

  // Capture accepted pair, then S1 diff and S2 accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_v     <= 1'b0;
      p0_first <= 1'b0;
      p0_last  <= 1'b0;
      p0_cur   <= '0;
      p0_ref   <= '0;
      p0_idx   <= '0;
      s1_v     <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_diff  <= '0;
      s1_idx   <= '0;
      acc      <= '0;
      c_v      <= 1'b0;
      c_sad    <= '0;
      c_idx    <= '0;
    end else begin
      p0_v     <= fire;
      p0_first <= (pix_cnt == '0);
      p0_last  <= last_pix;
      p0_cur   <= cur_pix;
      p0_ref   <= ref_pix;
      p0_idx   <= cand_cnt;
      s1_v     <= p0_v;
      s1_first <= p0_first;
      s1_last  <= p0_last;
      s1_diff  <= abs_diff;
      s1_idx   <= p0_idx;
      c_v      <= s1_v & s1_last;
      if (s1_v) begin
        acc <= sum;
        if (s1_last) begin
          c_sad <= sum;
          c_idx <= s1_idx;
        end
      end
    end
  end

  // S3 running minimum.
  always_ff @(posedge clk) begin
    if (rst) begin
      best   <= '0;
      best_i <= '0;
    end else if (start_go) begin
      best   <= SAD_INIT;
      best_i <= '0;
    end else if (c_v && replace) begin
      best   <= c_sad;
      best_i <= c_idx;
    end
  end

  // Result registers and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      done     <= 1'b0;
      best_sad <= '0;
      best_idx <= '0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        best_sad <= best;
        best_idx <= best_i;
      end
    end
  end

`ifdef SAD_CAND_OUT_EN
  assign cand_valid = c_v;
  assign cand_sad   = c_sad;
  assign cand_idx   = c_idx;
`endif

endmodule

// File: tb/tb_sad_block_ctrl.sv
// Randomized self-checking bench for sad_block_ctrl against a SAD model.
// Candidate-output checks active when SAD_CAND_OUT_EN is defined.
module tb_sad_block_ctrl;

  localparam int NP = 16;
  localparam int NC = 8;
  localparam int NT = NP * NC;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  cur_pix;
  logic [7:0]  ref_pix;
  logic        busy;
  logic        done;
  logic [11:0] best_sad;
  logic [2:0]  best_idx;
`ifdef SAD_CAND_OUT_EN
  logic        cand_valid;
  logic [11:0] cand_sad;
  logic [2:0]  cand_idx;
  int          cq_s[$];
  int          cq_i[$];
`endif

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;

  int cur_a[NT];
  int ref_a[NT];
  int exp_c[NC];

  sad_block_ctrl #(.N_PIX(NP), .N_CAND(NC)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cur_pix    (cur_pix),
    .ref_pix    (ref_pix),
    .busy       (busy),
    .done       (done),
`ifdef SAD_CAND_OUT_EN
    .cand_valid (cand_valid),
    .cand_sad   (cand_sad),
    .cand_idx   (cand_idx),
`endif
    .best_sad   (best_sad),
    .best_idx   (best_idx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) n_done++;
`ifdef SAD_CAND_OUT_EN
    if (cand_valid) begin
      cq_s.push_back(int'(cand_sad));
      cq_i.push_back(int'(cand_idx));
    end
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Reference: per-candidate SAD, then first strict minimum.
  task automatic model(output int b_sad, output int b_idx);
    b_sad = 4095;
    b_idx = 0;
    for (int c = 0; c < NC; c++) begin
      exp_c[c] = 0;
      for (int p = 0; p < NP; p++) begin
        int d;
        d = cur_a[c*NP+p] - ref_a[c*NP+p];
        exp_c[c] += (d < 0) ? -d : d;
      end
      if (exp_c[c] < b_sad) begin
        b_sad = exp_c[c];
        b_idx = c;
      end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NT; i++) begin
      cur_a[i] = int'($urandom_range(0, 255));
      ref_a[i] = int'($urandom_range(0, 255));
    end
  endtask

  task automatic run_search(input string nm, input bit gaps, input bit poke,
                            output int r_sad, output int r_idx);
    int idx;
    int guard;
    int lat;
    int base;
    int e_sad;
    int e_idx;
    bit acc;
    model(e_sad, e_idx);
`ifdef SAD_CAND_OUT_EN
    cq_s.delete();
    cq_i.delete();
`endif
    @(negedge clk);
    base = n_done;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({nm, "_busy_go"}, busy, 1);
    check({nm, "_rdy_go"}, in_ready, 1);
    idx = 0;
    guard = 0;
    while (idx < NT && guard < 4000) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      cur_pix = 8'(cur_a[idx]);
      ref_pix = 8'(ref_a[idx]);
      start = poke && (idx == 40);
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) idx++;
      guard++;
    end
    if (guard >= 4000) check({nm, "_accept_timeout"}, idx, NT);
    in_valid = 1'b0;
    start = poke;
    check({nm, "_rdy_drain"}, in_ready, 0);
    lat = 0;
    while (!done && lat < 12) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    check({nm, "_done_lat"}, lat, 4);
    check({nm, "_done"}, done, 1);
    check({nm, "_busy_end"}, busy, 0);
    check({nm, "_rdy_end"}, in_ready, 0);
    check({nm, "_best_sad"}, best_sad, e_sad);
    check({nm, "_best_idx"}, best_idx, e_idx);
    r_sad = int'(best_sad);
    r_idx = int'(best_idx);
    @(negedge clk);
    check({nm, "_done_pulse"}, done, 0);
    check({nm, "_done_cnt"}, n_done - base, 1);
    check({nm, "_hold_sad"}, best_sad, e_sad);
`ifdef SAD_CAND_OUT_EN
    check({nm, "_cand_n"}, cq_s.size(), NC);
    for (int c = 0; c < NC && c < cq_s.size(); c++) begin
      check({nm, "_cand_sad"}, cq_s[c], exp_c[c]);
      check({nm, "_cand_idx"}, cq_i[c], c);
    end
`endif
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_rdy"}, in_ready, 0);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_done"}, done, 0);
    check({nm, "_sad"}, best_sad, 0);
    check({nm, "_idx"}, best_idx, 0);
`ifdef SAD_CAND_OUT_EN
    check({nm, "_cv"}, cand_valid, 0);
    check({nm, "_cs"}, cand_sad, 0);
    check({nm, "_ci"}, cand_idx, 0);
`endif
  endtask

  initial begin
    int s1;
    int i1;
    int s2;
    int i2;
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    cur_pix = '0;
    ref_pix = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < NT; i++) begin
      cur_a[i] = 0;
      ref_a[i] = 0;
    end
    run_search("zeros", 1'b0, 1'b0, s1, i1);

    for (int i = 0; i < NT; i++) begin
      cur_a[i] = 255;
      ref_a[i] = (i / NP == 5) ? 255 : 0;
    end
    run_search("cand5", 1'b0, 1'b0, s1, i1);

    for (int i = 0; i < NT; i++) begin
      cur_a[i] = 0;
      ref_a[i] = 0;
    end
    for (int c = 0; c < NC; c++)
      ref_a[c*NP] = (c == 1 || c == 3) ? 100 : 200;
    run_search("tie", 1'b0, 1'b0, s1, i1);

    fill_random();
    run_search("b2b", 1'b0, 1'b0, s1, i1);
    run_search("gaps", 1'b1, 1'b0, s2, i2);
    check("gap_vs_b2b_sad", s2, s1);
    check("gap_vs_b2b_idx", i2, i1);

    fill_random();
    run_search("poke", 1'b1, 1'b1, s1, i1);

    // Reset while feeding candidate 3, pixel 7.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3*NP+7; i++) begin
      in_valid = 1'b1;
      cur_pix = 8'(cur_a[i]);
      ref_pix = 8'(ref_a[i]);
      @(negedge clk);
    end
    cur_pix = 8'(cur_a[3*NP+7]);
    ref_pix = 8'(ref_a[3*NP+7]);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_zero("midrst_hold");

    fill_random();
    run_search("post_rst", 1'b0, 1'b0, s1, i1);

    for (int k = 0; k < 3; k++) begin
      fill_random();
      for (int i = 0; i < NT; i++)
        if ($urandom_range(0, 3) == 0) ref_a[i] = cur_a[i];
      run_search("rand", k[0], 1'b0, s1, i1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
